alu_seq: RTL
============

# alu_seq

Multi-cycle sequencer that borrows the shared 8-bit ALU to run operations the single-cycle ALU cannot do in one pass. It supports shift-by-N, which repeats the ALU's 1-bit kSLL/kSRL, and 8×8 multiply, which iterates shift-and-add with kADD/kSLL/kSRL. It sits beside the core datapath. While it owns the ALU it asserts `alu_own`, and the top-level mux routes its op/operands to the ALU instead of the decoder's.

## Interface
- No parameters. Widths fixed at 8-bit data and 5-bit opcode.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 00 SHL, 01 SHR, 10 MUL, 11 reserved.
- `cmd_a` in 8: operand / multiplicand.
- `cmd_b` in 8: shift amount (bits [2:0] used, [7:3] ignored) / multiplier.
- `alu_own` out 1: sequencer drives the ALU this cycle.
- `alu_op` out 5: opcode to ALU (definitions constants).
- `alu_a` out 8: ALU in_a.
- `alu_b` out 8: ALU in_b.
- `alu_rslt` in 8: ALU rslt (combinational, same cycle).
- `alu_co` in 1: ALU carry-out.
- `busy` out 1: not IDLE.
- `done` out 1: one-cycle pulse, result valid.
- `res` out 8: result, held until next accept.
- `res_ovf` out 1: overflow/bits lost.
- `res_err` out 1: reserved op.

## Operation
- States: IDLE, SHIFT, MUL_ADD, MUL_SHA, MUL_SHB, DONE.
- **Accept:** IDLE & `cmd_valid`. Latch a→work, b→cnt/mult, clear acc and ovf. Next state:
  - SHIFT if cnt≠0.
  - MUL_ADD for MUL.
  - DONE otherwise; for reserved op, res=0 and err=1.
- **SHIFT:**
  - Issue kSLL/kSRL with alu_a=work, alu_b=0.
  - work←alu_rslt; ovf |= work[7] (SHL) or work[0] (SHR); cnt−1.
  - At cnt=1 go to DONE.
  - N=0 → DONE directly, res=cmd_a.
- **MUL iteration:**
  - MUL_ADD: kADD alu_a=acc, alu_b = mult[0] ? work : 8'h00. acc←rslt; ovf |= alu_co.
  - MUL_SHA: kSLL on work; ovf |= work[7] & ((mult>>1)≠0).
  - MUL_SHB: kSRL on mult.
  - Fixed 8 iterations, then DONE with res=acc.
- **DONE:** `done`=1, `busy`=1, `alu_own`=0, then IDLE.
- `alu_own`=1 in SHIFT/MUL_* only. When not owned, alu_op/alu_a/alu_b=0.
- `cmd_valid` outside IDLE is ignored; no queueing.
- **Reset values:** state IDLE, busy=0, done=0, alu_own=0, res=0, res_ovf=0, res_err=0, cmd_ready=1 from first post-reset cycle.
- **Reset mid-operation:** abort at next edge, same values as reset; no done pulse.

## Timing
- Accept in cycle t; one ALU op per cycle; result registered at end of each op cycle.
- `done` high in cycle t+K+1, where K = ALU ops issued.
  - SHIFT: K=N.
  - MUL, macro off: K=24, so done at t+25.
  - Reserved op or N=0: done at t+1.
- `cmd_ready` returns at t+K+2.
- res/res_ovf/res_err update on the edge into DONE and hold until the next accept.

## Configuration
- `ALU_SEQ_EARLY_EXIT_EN` defined:
  - MUL_ADD is skipped when mult[0]=0.
  - After MUL_SHB, if mult=0, go to DONE.
  - Latency is data-dependent, minimum K=2 for b=0.
- Undefined: fixed 24-op MUL, as above.
- Results and ovf are identical in both builds.

## Structure
- Add `alu_seq_op_e` (SHL/SHR/MUL/RSVD) and `alu_seq_state_e` to the `definitions` package.
- Opcodes use existing kADD/kSLL/kSRL.
- Single module, no sub-module: FSM and work/acc/mult/cnt registers share one always_ff.

## Test plan
- SHL a=0x81 b=3: alu_op kSLL×3 in t+1..t+3; done at t+4; res=0x08, ovf=1.
- SHR a=0xF0 b=0: done at t+1, res=0xF0, ovf=0; alu_own never high.
- MUL a=13 b=11: res=0x8F, ovf=0. Macro off: done at t+25.
- MUL a=0x20 b=0x09: res=0x20, ovf=1 (shift loss in iteration 2).
- Macro on, MUL a=5 b=2: ops SHA, SHB, ADD, SHA, SHB; done at t+6; res=0x0A.
- rst_n low at t+5 of MUL: next cycle IDLE, busy=0, alu_own=0, res=0, no done; new command accepted the cycle after rst_n rises. `cmd_valid` while busy: ignored.

Source files
------------

// File: rtl/definitions.sv
// Shared ALU opcodes and the multi-cycle sequencer's op/state encodings.
package definitions;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 5;

  localparam logic [OP_W-1:0] kADD = 5'h01;
  localparam logic [OP_W-1:0] kSLL = 5'h0A;
  localparam logic [OP_W-1:0] kSRL = 5'h0B;

  typedef enum logic [1:0] {
    OP_SHL  = 2'b00,
    OP_SHR  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } alu_seq_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_MUL_ADD,
    S_MUL_SHA,
    S_MUL_SHB,
    S_DONE
  } alu_seq_state_e;

endpackage

// File: rtl/alu_seq.sv
// Multi-cycle shift-by-N / 8x8 multiply sequencer that borrows the shared ALU.
// Optional ALU_SEQ_EARLY_EXIT_EN: skip zero-multiplier adds and stop once the multiplier is exhausted.
module alu_seq
  import definitions::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              alu_own,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_rslt,
  input  logic              alu_co,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic              res_ovf,
  output logic              res_err
);

  localparam int unsigned CNT_W = 4;

  alu_seq_state_e    state, state_next;
  alu_seq_op_e       op_q, cmd_op_e;
  logic [DATA_W-1:0] work, acc, mult;
  logic [CNT_W-1:0]  cnt;
  logic              ovf;
  logic              shift_lost, sha_lost;

  assign cmd_op_e   = alu_seq_op_e'(cmd_op);
  // Bit pushed out by the shift issued this cycle.
  assign shift_lost = (op_q == OP_SHR) ? work[0] : work[7];
  // A multiplicand bit lost only matters if a later multiplier bit could still add it.
  assign sha_lost   = work[7] & ((mult >> 1) != '0);

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= OP_SHL;
      work    <= '0;
      acc     <= '0;
      mult    <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      res     <= '0;
      res_ovf <= 1'b0;
      res_err <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (cmd_valid) begin
          op_q <= cmd_op_e;
          work <= cmd_a;
          mult <= cmd_b;
          acc  <= '0;
          ovf  <= 1'b0;
          cnt  <= (cmd_op_e == OP_MUL) ? CNT_W'(8) : CNT_W'(cmd_b[2:0]);
          if (state_next == S_DONE) begin
            res     <= (cmd_op_e == OP_RSVD) ? '0 : cmd_a;
            res_ovf <= 1'b0;
            res_err <= (cmd_op_e == OP_RSVD);
          end
        end
        S_SHIFT: begin
          work <= alu_rslt;
          ovf  <= ovf | shift_lost;
          cnt  <= cnt - CNT_W'(1);
          if (state_next == S_DONE) begin
            res     <= alu_rslt;
            res_ovf <= ovf | shift_lost;
            res_err <= 1'b0;
          end
        end
        S_MUL_ADD: begin
          acc <= alu_rslt;
          ovf <= ovf | alu_co;
        end
        S_MUL_SHA: begin
          work <= alu_rslt;
          ovf  <= ovf | sha_lost;
        end
        S_MUL_SHB: begin
          mult <= alu_rslt;
          cnt  <= cnt - CNT_W'(1);
          if (state_next == S_DONE) begin
            res     <= acc;
            res_ovf <= ovf;
            res_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (cmd_valid) begin
        case (cmd_op_e)
          OP_SHL, OP_SHR: state_next = (cmd_b[2:0] != 3'd0) ? S_SHIFT : S_DONE;
`ifdef ALU_SEQ_EARLY_EXIT_EN
          OP_MUL:         state_next = cmd_b[0] ? S_MUL_ADD : S_MUL_SHA;
`else
          OP_MUL:         state_next = S_MUL_ADD;
`endif
          default:        state_next = S_DONE;
        endcase
      end
      S_SHIFT:   if (cnt == CNT_W'(1)) state_next = S_DONE;
      S_MUL_ADD: state_next = S_MUL_SHA;
      S_MUL_SHA: state_next = S_MUL_SHB;
`ifdef ALU_SEQ_EARLY_EXIT_EN
      S_MUL_SHB: begin
        if (alu_rslt == '0)   state_next = S_DONE;
        else if (alu_rslt[0]) state_next = S_MUL_ADD;
        else                  state_next = S_MUL_SHA;
      end
`else
      S_MUL_SHB: state_next = (cnt == CNT_W'(1)) ? S_DONE : S_MUL_ADD;
`endif
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    cmd_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    alu_own   = 1'b0;
    alu_op    = '0;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      S_SHIFT: begin
        alu_own = 1'b1;
        alu_op  = (op_q == OP_SHR) ? kSRL : kSLL;
        alu_a   = work;
      end
      S_MUL_ADD: begin
        alu_own = 1'b1;
        alu_op  = kADD;
        alu_a   = acc;
        alu_b   = mult[0] ? work : '0;
      end
      S_MUL_SHA: begin
        alu_own = 1'b1;
        alu_op  = kSLL;
        alu_a   = work;
      end
      S_MUL_SHB: begin
        alu_own = 1'b1;
        alu_op  = kSRL;
        alu_a   = mult;
      end
      default: ;
    endcase
  end

endmodule
